aes_xts_block_sequencer: RTL and testbench
==========================================

Name: aes_xts_block_sequencer

Overview:
Sequences one XTS data unit through the AES-XTS-256 datapath. Drives the data-in register's write strobes, last-block flag and last-block size. Issues AES core start pulses and tweak-advance pulses, and handles ciphertext stealing when the final block is partial. Sits between the host stream interface and the data-in register / AES core / tweak generator.

Parameters:
BLOCK_CNT_W, 16, width of block count m (max 2^16-1 blocks per data unit)

Ports:
inClk  in  1  clock
inRstN  in  1  synchronous active-low reset
inStart  in  1  pulse; begins data unit, sampled only in S_IDLE
inNumBlocks  in  BLOCK_CNT_W  m = total blocks incl. partial last
inSizeLastData  in  8  valid bits in last block, 1..128 (128 = no stealing)
inExtValid  in  1  external 128-bit block available
outExtReady  out  1  sequencer accepts external block
outExtWr  out  1  data-in register external write = inExtValid & outExtReady
outIntWr  out  1  data-in register internal (stolen) write
outLastBlock  out  1  data-in register merge mode
outSizeLastData  out  8  latched inSizeLastData
outCoreStart  out  1  AES core start pulse
inCoreDone  in  1  AES core result-valid pulse
outTweakNext  out  1  pulse: tweak *= alpha
outOutValid  out  1  core result valid to downstream
outOutPartial  out  1  qualifies outOutValid: result is truncated C_m
outBusy  out  1  high outside S_IDLE
outDone  out  1  one-cycle pulse at end of data unit
outErr  out  1  one-cycle pulse on illegal config

Behaviour:
- Reset (inRstN=0 at posedge): state S_IDLE, block counter 0. All outputs 0, including outSizeLastData. Applies mid-operation with no drain.
- States: S_IDLE, S_FETCH, S_RUN, S_STEAL_FETCH, S_STEAL_RUN, S_DONE.
- S_IDLE + inStart: latch m and size.
  - Illegal if m==0, size==0, size>128, or (size<128 and m==1). Illegal: outErr pulse, remain S_IDLE.
  - Legal: go to S_FETCH. nFull = (size==128) ? m : m-1.
- S_FETCH:
  - outExtReady=1, outLastBlock=0. outLastBlock must stay 0 here: the register ignores a lone ext write in merge mode.
  - On inExtValid: outExtWr=1 (combinational), go to S_RUN. outCoreStart pulses exactly 1 cycle after outExtWr.
- S_RUN: wait for inCoreDone; counter++. outOutValid=1 in the done cycle.
  - counter<nFull: outTweakNext=1, go to S_FETCH.
  - counter==nFull, no stealing: go to S_DONE; no tweak pulse.
  - counter==nFull, stealing: outOutPartial=1 (downstream keeps first size bits as C_m), outTweakNext=1, go to S_STEAL_FETCH.
- S_STEAL_FETCH:
  - outExtReady=1, outLastBlock=1.
  - On inExtValid: outExtWr=1 and outIntWr=1 in the same cycle (merge P_m with stolen CC tail). Go to S_STEAL_RUN; outCoreStart 1 cycle later.
- S_STEAL_RUN: on inCoreDone, outOutValid=1, outOutPartial=0 (C_{m-1}), go to S_DONE.
- S_DONE: outDone=1 for one cycle, go to S_IDLE.
- inStart while busy is ignored. inCoreDone outside S_RUN/S_STEAL_RUN is ignored. inExtValid outside fetch states is ignored.
- Simultaneous inCoreDone and inExtValid in a RUN state: only done is processed.
- Block counter is BLOCK_CNT_W bits and never wraps: the terminal compare against nFull is exact.

Optional Feature:
AES_XTS_SEQ_DECRYPT_EN:
- Defined: adds ports inDecrypt (sampled with inStart), outTweakSave and outTweakRestore.
  - For a decrypt with stealing, block m-1 uses T_m and the stolen block uses T_{m-1}.
  - On entering the block m-1 fetch: outTweakSave then outTweakNext on consecutive cycles, both before outCoreStart.
  - On that block's inCoreDone: outTweakRestore instead of outTweakNext.
- Undefined: encrypt only; ports absent.

Decomposition:
- Package aes_xts_seq_pkg: state enum; AES_BLOCK_BITS=128; SIZE_W=8; illegal-config check function.
- Sub-module aes_xts_blk_counter: load/increment/terminal-compare counter, BLOCK_CNT_W wide.

Test Plan:
- m=3, size=128, inExtValid always 1 -> 3 outExtWr, 3 outCoreStart (each 1 cycle after write), 2 outTweakNext, 3 outOutValid, outIntWr never high, 1 outDone.
- m=2, size=40 -> first outOutValid with outOutPartial=1. Then outLastBlock=1 with outExtWr&outIntWr in one cycle, outSizeLastData=40. Second outOutValid with partial=0, then outDone.
- m=1 size=64; m=0 size=128; m=4 size=0 -> each gives outErr pulse, outBusy stays 0.
- m=2, size=128, inExtValid low 5 cycles in S_FETCH plus spurious inCoreDone -> no write, no core start, counter unchanged.
- inRstN=0 during S_STEAL_RUN -> next cycle all outputs 0, S_IDLE; new inStart m=1 size=128 completes normally.
- AES_XTS_SEQ_DECRYPT_EN defined, inDecrypt=1, m=2, size=40 -> outTweakSave, outTweakNext before block-0 start; outTweakRestore on its done.

Source files
------------

// File: rtl/aes_xts_seq_pkg.sv
// Shared state encoding, sizes and config check for the AES-XTS block sequencer.
package aes_xts_seq_pkg;

   localparam int AES_BLOCK_BITS = 128;
   localparam int SIZE_W         = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_RUN,
      S_STEAL_FETCH,
      S_STEAL_RUN,
      S_DONE
   } seqState_t;

   // Decrypt-with-stealing tweak shuffle ahead of block m-1
   typedef enum logic [1:0] {
      TW_SAVE,
      TW_NEXT,
      TW_DONE
   } tweakPhase_t;

   // A partial last block needs a full block in front of it to steal from.
   function automatic logic isIllegalCfg(input logic numIsZero,
                                         input logic numIsOne,
                                         input logic [SIZE_W-1:0] sizeLast);
      logic stealing;
      stealing = (sizeLast != SIZE_W'(AES_BLOCK_BITS));
      return numIsZero || (sizeLast == '0) ||
             (sizeLast > SIZE_W'(AES_BLOCK_BITS)) || (stealing && numIsOne);
   endfunction

endpackage

// File: rtl/aes_xts_blk_counter.sv
// Block counter: cleared with a terminal value on load, saturates at that terminal.
module aes_xts_blk_counter #(
   parameter int BLOCK_CNT_W = 16
) (
   input  logic                   inClk,
   input  logic                   inRstN,
   input  logic                   inLoad,
   input  logic [BLOCK_CNT_W-1:0] inTerminal,
   input  logic                   inInc,
   output logic                   outAtTerm
);

   logic [BLOCK_CNT_W-1:0] countReg;
   logic [BLOCK_CNT_W-1:0] termReg;
   logic [BLOCK_CNT_W-1:0] countPlusOne;

   assign countPlusOne = countReg + 1'b1;
   // High while the block in flight is the last full one.
   assign outAtTerm    = (countReg != termReg) && (countPlusOne == termReg);

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         countReg <= '0;
         termReg  <= '0;
      end else if (inLoad) begin
         countReg <= '0;
         termReg  <= inTerminal;
      end else if (inInc && (countReg != termReg)) begin
         countReg <= countPlusOne;
      end
   end

endmodule

// File: rtl/aes_xts_block_sequencer.sv
// Sequences one XTS data unit through data-in register, AES core and tweak generator.
// Optional decrypt tweak handling: define AES_XTS_SEQ_DECRYPT_EN.
module aes_xts_block_sequencer
   import aes_xts_seq_pkg::*;
#(
   parameter int BLOCK_CNT_W = 16
) (
   input  logic                   inClk,
   input  logic                   inRstN,
   input  logic                   inStart,
   input  logic [BLOCK_CNT_W-1:0] inNumBlocks,
   input  logic [SIZE_W-1:0]      inSizeLastData,
   input  logic                   inExtValid,
   output logic                   outExtReady,
   output logic                   outExtWr,
   output logic                   outIntWr,
   output logic                   outLastBlock,
   output logic [SIZE_W-1:0]      outSizeLastData,
   output logic                   outCoreStart,
   input  logic                   inCoreDone,
   output logic                   outTweakNext,
`ifdef AES_XTS_SEQ_DECRYPT_EN
   input  logic                   inDecrypt,
   output logic                   outTweakSave,
   output logic                   outTweakRestore,
`endif
   output logic                   outOutValid,
   output logic                   outOutPartial,
   output logic                   outBusy,
   output logic                   outDone,
   output logic                   outErr
);

   seqState_t              stateReg, stateNext;
   logic                   stealReg;
   logic                   coreStartReg;
   logic                   errReg, errNext;
   logic [SIZE_W-1:0]      sizeReg;
   logic                   cntLoad, cntInc, cntAtTerm;
   logic [BLOCK_CNT_W-1:0] nFullLoad;
   logic                   stealIn, cfgIllegal, twHold;

   assign stealIn    = (inSizeLastData != SIZE_W'(AES_BLOCK_BITS));
   assign cfgIllegal = isIllegalCfg(inNumBlocks == '0, inNumBlocks == BLOCK_CNT_W'(1),
                                    inSizeLastData);
   assign nFullLoad  = stealIn ? (inNumBlocks - 1'b1) : inNumBlocks;

   aes_xts_blk_counter #(
      .BLOCK_CNT_W (BLOCK_CNT_W)
   ) uBlkCounter (
      .inClk      (inClk),
      .inRstN     (inRstN),
      .inLoad     (cntLoad),
      .inTerminal (nFullLoad),
      .inInc      (cntInc),
      .outAtTerm  (cntAtTerm)
   );

`ifdef AES_XTS_SEQ_DECRYPT_EN
   logic        decryptReg;
   tweakPhase_t twPhaseReg, twPhaseNext;

   // Fetch of block m-1 is held off until the tweak is saved and advanced.
   assign twHold = decryptReg && stealReg && cntAtTerm && (twPhaseReg != TW_DONE);

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         decryptReg <= 1'b0;
         twPhaseReg <= TW_SAVE;
      end else begin
         twPhaseReg <= twPhaseNext;
         if ((stateReg == S_IDLE) && inStart) decryptReg <= inDecrypt;
      end
   end
`else
   assign twHold = 1'b0;
`endif

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         stateReg     <= S_IDLE;
         stealReg     <= 1'b0;
         sizeReg      <= '0;
         coreStartReg <= 1'b0;
         errReg       <= 1'b0;
      end else begin
         stateReg     <= stateNext;
         coreStartReg <= outExtWr;
         errReg       <= errNext;
         if ((stateReg == S_IDLE) && inStart) begin
            sizeReg  <= inSizeLastData;
            stealReg <= stealIn;
         end
      end
   end

   always_comb begin
      stateNext     = stateReg;
      outExtReady   = 1'b0;
      outIntWr      = 1'b0;
      outLastBlock  = 1'b0;
      outTweakNext  = 1'b0;
      outOutValid   = 1'b0;
      outOutPartial = 1'b0;
      outDone       = 1'b0;
      errNext       = 1'b0;
      cntLoad       = 1'b0;
      cntInc        = 1'b0;
`ifdef AES_XTS_SEQ_DECRYPT_EN
      outTweakSave    = 1'b0;
      outTweakRestore = 1'b0;
      twPhaseNext     = twPhaseReg;
`endif
      case (stateReg)
         S_IDLE: begin
            if (inStart) begin
               if (cfgIllegal) begin
                  errNext = 1'b1;
               end else begin
                  cntLoad   = 1'b1;
                  stateNext = S_FETCH;
`ifdef AES_XTS_SEQ_DECRYPT_EN
                  twPhaseNext = TW_SAVE;
`endif
               end
            end
         end
         S_FETCH: begin
            if (twHold) begin
`ifdef AES_XTS_SEQ_DECRYPT_EN
               if (twPhaseReg == TW_SAVE) begin
                  outTweakSave = 1'b1;
                  twPhaseNext  = TW_NEXT;
               end else begin
                  outTweakNext = 1'b1;
                  twPhaseNext  = TW_DONE;
               end
`endif
            end else begin
               // Merge mode stays off: a lone external write must land as-is.
               outExtReady = 1'b1;
               if (inExtValid) stateNext = S_RUN;
            end
         end
         S_RUN: begin
            if (inCoreDone) begin
               outOutValid = 1'b1;
               cntInc      = 1'b1;
               if (!cntAtTerm) begin
                  outTweakNext = 1'b1;
                  stateNext    = S_FETCH;
               end else if (stealReg) begin
                  outOutPartial = 1'b1;
                  stateNext     = S_STEAL_FETCH;
`ifdef AES_XTS_SEQ_DECRYPT_EN
                  if (decryptReg) outTweakRestore = 1'b1;
                  else            outTweakNext    = 1'b1;
`else
                  outTweakNext = 1'b1;
`endif
               end else begin
                  stateNext = S_DONE;
               end
            end
         end
         S_STEAL_FETCH: begin
            outExtReady  = 1'b1;
            outLastBlock = 1'b1;
            if (inExtValid) begin
               outIntWr  = 1'b1;
               stateNext = S_STEAL_RUN;
            end
         end
         S_STEAL_RUN: begin
            if (inCoreDone) begin
               outOutValid = 1'b1;
               stateNext   = S_DONE;
            end
         end
         S_DONE: begin
            outDone   = 1'b1;
            stateNext = S_IDLE;
         end
         default: stateNext = S_IDLE;
      endcase
   end

   assign outExtWr        = inExtValid & outExtReady;
   assign outCoreStart    = coreStartReg;
   assign outErr          = errReg;
   assign outSizeLastData = sizeReg;
   assign outBusy         = (stateReg != S_IDLE);

endmodule

// File: tb/tb_aes_xts_block_sequencer.sv
// Randomized self-checking bench: event counts and ordering checked against XTS rules.
`timescale 1ns/1ps
module tb_aes_xts_block_sequencer;

   logic        inClk;
   logic        inRstN;
   logic        inStart;
   logic [15:0] inNumBlocks;
   logic [7:0]  inSizeLastData;
   logic        inExtValid;
   logic        outExtReady, outExtWr, outIntWr, outLastBlock;
   logic [7:0]  outSizeLastData;
   logic        outCoreStart;
   logic        inCoreDone;
   logic        outTweakNext;
`ifdef AES_XTS_SEQ_DECRYPT_EN
   logic        inDecrypt;
   logic        outTweakSave, outTweakRestore;
`endif
   logic        outOutValid, outOutPartial, outBusy, outDone, outErr;

   aes_xts_block_sequencer #(.BLOCK_CNT_W(16)) dut (
      .inClk           (inClk),
      .inRstN          (inRstN),
      .inStart         (inStart),
      .inNumBlocks     (inNumBlocks),
      .inSizeLastData  (inSizeLastData),
      .inExtValid      (inExtValid),
      .outExtReady     (outExtReady),
      .outExtWr        (outExtWr),
      .outIntWr        (outIntWr),
      .outLastBlock    (outLastBlock),
      .outSizeLastData (outSizeLastData),
      .outCoreStart    (outCoreStart),
      .inCoreDone      (inCoreDone),
      .outTweakNext    (outTweakNext),
`ifdef AES_XTS_SEQ_DECRYPT_EN
      .inDecrypt       (inDecrypt),
      .outTweakSave    (outTweakSave),
      .outTweakRestore (outTweakRestore),
`endif
      .outOutValid     (outOutValid),
      .outOutPartial   (outOutPartial),
      .outBusy         (outBusy),
      .outDone         (outDone),
      .outErr          (outErr)
   );

   initial inClk = 1'b0;
   always #5 inClk = ~inClk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int nExtWr, nIntWr, nCoreStart, nTweakNext, nValid, nPartial, nDone, nErr, nBusy;
   int nSave, nRestore;
   int curM, curSize;
   bit curSteal, curDec;
   bit prevExtWr = 1'b0;
   bit pend = 1'b0;
   int cd = 0;
   int extMode = 0;
   int holdLeft = 0;
   bit startReq = 1'b0;
   bit rstReq = 1'b0;
   bit expNextAfterSave = 1'b0;

   task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] outVec();
      logic [31:0] v;
      v = 32'({outExtReady, outExtWr, outIntWr, outLastBlock, outSizeLastData, outCoreStart,
               outTweakNext, outOutValid, outOutPartial, outBusy, outDone, outErr});
`ifdef AES_XTS_SEQ_DECRYPT_EN
      v = v | (32'({outTweakSave, outTweakRestore}) << 20);
`endif
      return v;
   endfunction

   // Stimulus for the coming posedge: host stream, core latency model, misuse.
   task automatic drive();
      inStart = startReq;
      startReq = 1'b0;
      inRstN = 1'b1;
      inCoreDone = 1'b0;
      if (pend) begin
         cd--;
         if (cd <= 0) begin
            inCoreDone = 1'b1;
            pend = 1'b0;
         end
      end
      case (extMode)
         1: inExtValid = 1'b1;
         2: inExtValid = 1'b0;
         default: inExtValid = ($urandom_range(0, 3) != 0);
      endcase
      if (!inStart && outBusy && ($urandom_range(0, 9) == 0)) inStart = 1'b1;
      if (holdLeft > 0 && outExtReady) begin
         inExtValid = 1'b0;
         inCoreDone = 1'b1;
         holdLeft--;
      end
      if (rstReq) begin
         inRstN = 1'b0;
         inCoreDone = 1'b0;
         pend = 1'b0;
         rstReq = 1'b0;
      end
   endtask

   task automatic sample();
      bit expLast;
      cyc++;
      if (outCoreStart || prevExtWr) checkEq("coreStartLag", outCoreStart, prevExtWr);
      prevExtWr = outExtWr;
      if (outCoreStart) begin
         nCoreStart++;
         pend = 1'b1;
         cd = $urandom_range(1, 3);
      end
      if (outExtWr) begin
         expLast = curSteal && (nExtWr == curM - 1);
         checkEq("lastBlock", outLastBlock, expLast);
         checkEq("intWrMerge", outIntWr, expLast);
         if (expLast) checkEq("sizeLast", outSizeLastData, curSize);
         nExtWr++;
      end
      if (outIntWr) nIntWr++;
`ifdef AES_XTS_SEQ_DECRYPT_EN
      if (expNextAfterSave) begin
         checkEq("nextAfterSave", outTweakNext, 1);
         expNextAfterSave = 1'b0;
      end
      if (outTweakSave) begin
         nSave++;
         checkEq("saveBeforeStart", nCoreStart, curM - 2);
         expNextAfterSave = 1'b1;
      end
      if (outTweakRestore) begin
         nRestore++;
         checkEq("restoreOnDone", outOutValid && (nValid == curM - 2), 1);
      end
`endif
      if (outTweakNext) nTweakNext++;
      if (outOutValid) begin
         checkEq("partialFlag", outOutPartial, curSteal && (nValid == curM - 2));
         nValid++;
      end
      if (outOutPartial) nPartial++;
      if (outDone) begin
         nDone++;
         checkEq("busyAtDone", outBusy, 1);
      end
      if (outErr) nErr++;
      if (outBusy) nBusy++;
   endtask

   task automatic step();
      @(negedge inClk);
      drive();
      #1;
      sample();
   endtask

   task automatic runSeq(input int m, input int size, input bit dec, input int hold,
                         input bit rstAtSteal);
      int budget;
      bit legal, expSteal;
      expSteal = (size != 128);
      legal = (m > 0) && (size > 0) && (size <= 128) && !(expSteal && m == 1);
      nExtWr = 0; nIntWr = 0; nCoreStart = 0; nTweakNext = 0; nValid = 0;
      nPartial = 0; nDone = 0; nErr = 0; nBusy = 0; nSave = 0; nRestore = 0;
      curM = m; curSize = size; curSteal = expSteal; curDec = dec;
      inNumBlocks = 16'(m);
      inSizeLastData = 8'(size);
`ifdef AES_XTS_SEQ_DECRYPT_EN
      inDecrypt = dec;
`endif
      holdLeft = hold;
      startReq = 1'b1;
      step();
      if (!legal) begin
         repeat (4) step();
         checkEq("errPulse", nErr, 1);
         checkEq("errNotBusy", nBusy, 0);
         $display("txn m=%0d size=%0d illegal err=%0d busy=%0d", m, size, nErr, nBusy);
         return;
      end
      if (hold > 0) begin
         budget = 0;
         while (holdLeft > 0 && budget < 50) begin
            step();
            budget++;
         end
         checkEq("holdNoWrite", nExtWr, 0);
         checkEq("holdNoStart", nCoreStart, 0);
         checkEq("holdNoValid", nValid, 0);
         checkEq("holdBusy", outBusy, 1);
      end
      budget = 0;
      while (nDone == 0 && budget < 400) begin
         step();
         budget++;
         if (rstAtSteal && outCoreStart && nIntWr == 1) begin
            rstReq = 1'b1;
            step();
            step();
            checkEq("rstOutputs", outVec(), 0);
            $display("txn m=%0d size=%0d reset in steal run outs=%0h", m, size, outVec());
            return;
         end
      end
      checkEq("doneSeen", nDone, 1);
      checkEq("extWrCount", nExtWr, m);
      checkEq("intWrCount", nIntWr, expSteal);
      checkEq("coreStartCount", nCoreStart, m);
      checkEq("tweakNextCount", nTweakNext, m - 1);
      checkEq("validCount", nValid, m);
      checkEq("partialCount", nPartial, expSteal);
      checkEq("errCount", nErr, 0);
`ifdef AES_XTS_SEQ_DECRYPT_EN
      checkEq("saveCount", nSave, dec && expSteal);
      checkEq("restoreCount", nRestore, dec && expSteal);
`endif
      step();
      checkEq("idleAfterDone", outBusy, 0);
      $display("txn m=%0d size=%0d dec=%0d wr=%0d int=%0d start=%0d next=%0d valid=%0d part=%0d",
               m, size, dec, nExtWr, nIntWr, nCoreStart, nTweakNext, nValid, nPartial);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m, size;
      bit dec;
      inRstN = 1'b0;
      inStart = 1'b0;
      inNumBlocks = '0;
      inSizeLastData = '0;
      inExtValid = 1'b0;
      inCoreDone = 1'b0;
`ifdef AES_XTS_SEQ_DECRYPT_EN
      inDecrypt = 1'b0;
`endif
      repeat (3) @(negedge inClk);
      #1;
      checkEq("resetState", outVec(), 0);

      extMode = 1;
      runSeq(3, 128, 1'b0, 0, 1'b0);
      extMode = 0;
      runSeq(2, 40, 1'b0, 0, 1'b0);
      runSeq(1, 64, 1'b0, 0, 1'b0);
      runSeq(0, 128, 1'b0, 0, 1'b0);
      runSeq(4, 0, 1'b0, 0, 1'b0);
      runSeq(3, 200, 1'b0, 0, 1'b0);
      runSeq(2, 128, 1'b0, 5, 1'b0);
      runSeq(2, 40, 1'b0, 0, 1'b1);
      runSeq(1, 128, 1'b0, 0, 1'b0);
      runSeq(2, 1, 1'b0, 0, 1'b0);
      runSeq(5, 127, 1'b0, 0, 1'b0);
`ifdef AES_XTS_SEQ_DECRYPT_EN
      runSeq(2, 40, 1'b1, 0, 1'b0);
      runSeq(4, 100, 1'b1, 0, 1'b0);
`endif
      for (int i = 0; i < 25; i++) begin
         m = $urandom_range(1, 6);
         size = ($urandom_range(0, 2) == 0) ? 128 : $urandom_range(1, 127);
         if (m == 1) size = 128;
         dec = 1'b0;
`ifdef AES_XTS_SEQ_DECRYPT_EN
         dec = 1'($urandom_range(0, 1));
`endif
         runSeq(m, size, dec, 0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
